// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Digit-serial add/subtract (DIGIT bits per clock, LSB first) with
//           carry-in, carry-out and signed overflow; start/busy/done handshake.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v
);

    localparam int C_N  = WIDTH / DIGIT;
    localparam int C_CW = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(C_N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [C_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [WIDTH-1:0]  r_s;
    logic              r_c;
    logic              r_v;
    logic              r_done;
    logic              w_last;
    logic [DIGIT-1:0]  w_dig_sum;
    logic [DIGIT:0]    w_dc;
    logic [WIDTH-1:0]  w_sum_next;

    assign w_last = (r_cnt == C_LAST);
    assign w_dc[0] = r_carry;

    // Each digit bit is a full adder formed from two half adders.
    for (genvar i = 0; i < DIGIT; i++) begin : g_digit
        logic w_p;
        logic w_g;
        logic w_pc;
        assign w_p          = r_a[i] ^ r_b[i];
        assign w_g          = r_a[i] & r_b[i];
        assign w_dig_sum[i] = w_p ^ w_dc[i];
        assign w_pc         = w_p & w_dc[i];
        assign w_dc[i+1]    = w_g | w_pc;
    end

    // Partial result holds only the bits still needed; new digits enter at the top.
    if (DIGIT < WIDTH) begin : g_part
        logic [WIDTH-DIGIT-1:0] r_part;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_part <= '0;
            end else if (r_state == S_RUN) begin
                r_part <= w_sum_next[WIDTH-1:DIGIT];
            end
        end
        assign w_sum_next = {w_dig_sum, r_part};
    end else begin : g_full
        assign w_sum_next = w_dig_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= cin ^ sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dc[DIGIT];
                    r_cnt   <= r_cnt + C_CW'(1);
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_s    <= w_sum_next;
                        r_c    <= w_dc[DIGIT];
                        r_v    <= w_dc[DIGIT] ^ w_dc[DIGIT-1];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign s    = r_s;
    assign c    = r_c;
    assign v    = r_v;

endmodule

`default_nettype wire
